// File: rtl/pc_select_unit_if.sv
// pc_select_unit_if: control-side bundle for the PC select unit.
// master = control unit / bench, slave = pc_select_unit.
interface pc_select_unit_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          src_sel;
  logic                      pc_write;
  logic                      pc_write_cond;
  logic                      cond_true;
  logic [2:0]                exc_req;
  logic [DATA_W-1:0]         pc_out;
  logic [DATA_W-1:0]         epc_out;
  logic [1:0]                cause_out;
  logic                      exc_ack;
  logic                      busy;
  logic                      sel_err;

  modport master (
    output src_data, src_sel, pc_write,
    output pc_write_cond, cond_true, exc_req,
    input  pc_out, epc_out, cause_out,
    input  exc_ack, busy, sel_err
  );

  modport slave (
    input  src_data, src_sel, pc_write,
    input  pc_write_cond, cond_true, exc_req,
    output pc_out, epc_out, cause_out,
    output exc_ack, busy, sel_err
  );
endinterface

// File: rtl/pc_select_unit.sv
// pc_select_unit: PC register, next-PC mux, exception sequencer.
// Optional macro PC_ALIGN_CHECK_EN: misaligned loads trap, cause 3.
module pc_select_unit #(
  parameter int              DATA_W       = 32,
  parameter int              NUM_SRC      = 4,
  parameter int              SEL_W        = 2,
  parameter logic [DATA_W-1:0] RESET_PC     = '0,
  parameter logic [DATA_W-1:0] EXC_VEC_BASE = DATA_W'(32'h0000_00FC)
) (
  input logic clk,
  input logic reset_n,
  pc_select_unit_if.slave bus
);

  typedef enum logic {IDLE, VECTOR} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              ack_q, ack_d;
  logic              serr_q, serr_d;

  logic [DATA_W-1:0] srcs [NUM_SRC];
  logic [DATA_W-1:0] src_val;
  logic [31:0]       sel_idx;
  logic              sel_ok;
  logic              load;

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      srcs[k] = bus.src_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    sel_idx = 32'(bus.src_sel);
    sel_ok  = sel_idx < NUM_SRC;
    src_val = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_idx == k) src_val = srcs[k];
    end
  end

  assign load = bus.pc_write
              | (bus.pc_write_cond & bus.cond_true);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    ack_d   = 1'b0;
    serr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.exc_req) begin
          // exception wins over a same-cycle load
          epc_d   = pc_q - DATA_W'(4);
          state_d = VECTOR;
          if (bus.exc_req[0])      cause_d = 2'd0;
          else if (bus.exc_req[1]) cause_d = 2'd1;
          else                     cause_d = 2'd2;
        end else if (load) begin
          if (!sel_ok) begin
            serr_d = 1'b1;
          end
`ifdef PC_ALIGN_CHECK_EN
          else if (src_val[1:0] != 2'b00) begin
            epc_d   = pc_q - DATA_W'(4);
            cause_d = 2'd3;
            state_d = VECTOR;
          end
`endif
          else begin
            pc_d = src_val;
          end
        end
      end
      VECTOR: begin
        // inputs ignored: no nesting
        pc_d    = EXC_VEC_BASE + DATA_W'({cause_q, 2'b00});
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= 2'd0;
      ack_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      ack_q   <= ack_d;
      serr_q  <= serr_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.epc_out   = epc_q;
  assign bus.cause_out = cause_q;
  assign bus.exc_ack   = ack_q;
  assign bus.sel_err   = serr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pc_select_unit.sv
// tb_pc_select_unit: scoreboard bench for pc_select_unit.
// Three sources so an out-of-range select is reachable.
module tb_pc_select_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        ack;
    logic        busy;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_select_unit_if #(
    .DATA_W(32), .NUM_SRC(3), .SEL_W(2)
  ) bus ();

  pc_select_unit #(
    .DATA_W(32), .NUM_SRC(3), .SEL_W(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];

  logic [31:0] src [3];
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_vec;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_epc = 32'h0;
    m_cause = 2'd0; m_vec = 1'b0;
  endtask

  task automatic check_out(input exp_t e);
    chk("pc", bus.pc_out, e.pc);
    chk("epc", bus.epc_out, e.epc);
    chk("cause", 32'(bus.cause_out), 32'(e.cause));
    chk("ack", 32'(bus.exc_ack), 32'(e.ack));
    chk("busy", 32'(bus.busy), 32'(e.busy));
    chk("sel_err", 32'(bus.sel_err), 32'(e.err));
  endtask

  // drive one cycle, predict, advance, compare
  task automatic step(input logic [1:0] sel,
                      input logic pw, input logic pwc,
                      input logic ct, input logic [2:0] exc);
    exp_t e;
    logic ld;
    logic [31:0] v;
    bus.src_data = {src[2], src[1], src[0]};
    bus.src_sel = sel;
    bus.pc_write = pw;
    bus.pc_write_cond = pwc;
    bus.cond_true = ct;
    bus.exc_req = exc;
    ld = pw | (pwc & ct);
    e.pc = m_pc; e.epc = m_epc; e.cause = m_cause;
    e.ack = 1'b0; e.err = 1'b0;
    if (m_vec) begin
      e.pc = 32'hFC + 32'd4 * 32'(m_cause);
      e.ack = 1'b1;
      m_vec = 1'b0;
    end else if (exc != 3'b000) begin
      e.epc = m_pc - 32'd4;
      case (1'b1)
        exc[0]:  e.cause = 2'd0;
        exc[1]:  e.cause = 2'd1;
        default: e.cause = 2'd2;
      endcase
      m_vec = 1'b1;
    end else if (ld) begin
      if (sel == 2'd3) e.err = 1'b1;
      else begin
        v = src[sel];
`ifdef PC_ALIGN_CHECK_EN
        if (v[1:0] != 2'b00) begin
          e.epc = m_pc - 32'd4;
          e.cause = 2'd3;
          m_vec = 1'b1;
        end else e.pc = v;
`else
        e.pc = v;
`endif
      end
    end
    e.busy = m_vec;
    m_pc = e.pc; m_epc = e.epc; m_cause = e.cause;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(sb.pop_front());
  endtask

  task automatic idle();
    step(2'd0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    exp_t r;
    src[0] = 32'h0; src[1] = 32'h0; src[2] = 32'h0;
    bus.src_data = '0;
    bus.src_sel = '0;
    bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.cond_true = 1'b0;
    bus.exc_req = 3'b000;
    m_reset();
    #2;
    r = '{pc:32'h0, epc:32'h0, cause:2'd0,
          ack:1'b0, busy:1'b0, err:1'b0};
    check_out(r);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // plain load, then hold
    src[2] = 32'h40;
    step(2'd2, 1'b1, 1'b0, 1'b0, 3'b000);
    chk("load_40", bus.pc_out, 32'h40);
    idle();
    chk("hold_40", bus.pc_out, 32'h40);

    // conditional load
    src[1] = 32'h100;
    step(2'd1, 1'b0, 1'b1, 1'b0, 3'b000);
    chk("cond_false", bus.pc_out, 32'h40);
    step(2'd1, 1'b0, 1'b1, 1'b1, 3'b000);
    chk("cond_true", bus.pc_out, 32'h100);

    // exception beats load
    src[0] = 32'h20;
    step(2'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    step(2'd1, 1'b1, 1'b0, 1'b0, 3'b110);
    chk("epc_1c", bus.epc_out, 32'h1C);
    chk("cause_1", 32'(bus.cause_out), 32'd1);
    step(2'd2, 1'b1, 1'b0, 1'b0, 3'b001);
    chk("vec_100", bus.pc_out, 32'h100);
    chk("cause_kept", 32'(bus.cause_out), 32'd1);
    // accepted on ack cycle
    step(2'd0, 1'b0, 1'b0, 1'b0, 3'b001);
    chk("epc_fc", bus.epc_out, 32'hFC);
    idle();
    chk("vec_fc", bus.pc_out, 32'hFC);
    idle();

    // out-of-range select
    step(2'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    chk("serr_hold", bus.pc_out, 32'hFC);
    idle();

    // async reset while in VECTOR
    step(2'd0, 1'b0, 1'b0, 1'b0, 3'b100);
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    check_out(r);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // misaligned source
    src[0] = 32'h10;
    step(2'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    src[0] = 32'h42;
    step(2'd0, 1'b1, 1'b0, 1'b0, 3'b000);
`ifdef PC_ALIGN_CHECK_EN
    chk("no_42", 32'(bus.pc_out != 32'h42), 32'd1);
    idle();
    chk("al_epc", bus.epc_out, 32'hC);
    chk("al_cause", 32'(bus.cause_out), 32'd3);
    chk("al_vec", bus.pc_out, 32'h108);
`else
    chk("mis_load", bus.pc_out, 32'h42);
`endif
    idle();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        src[k] = $urandom;
        if ($urandom_range(0, 3) != 0) src[k][1:0] = 2'b00;
      end
      step(2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0)
             ? 3'($urandom_range(1, 7)) : 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
